direction_deque: RTL and testbench
==================================

# direction_deque

Circular-buffer deque holding the 2-bit move directions produced by the maze-solver controller. It sits directly downstream of the controller:
- push appends the direction of each successful step at the back;
- pop_back returns the last step during backtracking (stack_out);
- pop_front replays the solved path from the start during path display (front_out).

Emptiness and fullness status feed back to the controller.

## Interface
Parameters:
- DEPTH, 256: number of 2-bit entries; power of two, ≥ 4 (covers a 16x16 maze).
- AW, $clog2(DEPTH): pointer width.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  reset; asynchronous, active-high; clears pointers, count, outputs and flags.
- our_reset  in  1  synchronous clear, same effect as Rst, at the next edge.
- push  in  1  append dir at back.
- pop_back  in  1  remove back entry, register it on stack_out.
- pop_front  in  1  remove front entry, register it on front_out.
- dir  in  2  direction to push (00 up, 01 right, 10 left, 11 down).
- stack_out  out  2  last entry removed by pop_back.
- front_out  out  2  last entry removed by pop_front.
- front_valid  out  1  one-cycle pulse; front_out updated this cycle.
- is_deque_empty  out  1  count == 0, combinational from registered count.
- is_deque_full  out  1  count == DEPTH, combinational.
- ovf  out  1  sticky: push attempted while full.
- udf  out  1  sticky: pop attempted while empty.

## Operation
State:
- mem[DEPTH] x 2 bits;
- head (front index) and tail (next free back index), AW bits each, wrap modulo DEPTH;
- count, AW+1 bits.

Per-cycle priority (one operation per edge): our_reset > pop_back > pop_front > push. Lower-priority requests in the same cycle are dropped silently; no flag is set.
- push, not full: mem[tail] <= dir; tail <= tail+1; count+1.
- push, full: no change; ovf <= 1.
- pop_back, not empty: stack_out <= mem[tail-1]; tail <= tail-1; count-1.
- pop_front, not empty: front_out <= mem[head]; head <= head+1; count-1; front_valid <= 1.
- pop on empty: pointers, count and outputs unchanged; udf <= 1; front_valid stays 0.
- our_reset: head = tail = count = 0; stack_out = front_out = 00; front_valid = ovf = udf = 0. Memory contents are don't-care.

Pointer rules:
- Pointer arithmetic is unsigned AW-bit wrap-around.
- tail-1 from 0 yields DEPTH-1.
- head and tail may sit anywhere in the ring; only count distinguishes full from empty when head == tail.

## Timing
- Reset values: stack_out = 00, front_out = 00, front_valid = 0, is_deque_empty = 1, is_deque_full = 0, ovf = 0, udf = 0.
- Push latency: entry is visible to a pop in the next cycle; is_deque_empty falls the cycle after the first push.
- pop_back at edge N: stack_out is valid from after edge N, so the controller samples it in the following state. is_deque_empty reflects the post-pop count in that same cycle.
- Removing the last entry: stack_out holds that entry while is_deque_empty = 1. The consumer must evaluate stack_out before empty.
- pop_front held continuously: one entry per cycle, front_valid high each cycle an entry is removed. The cycle after the last removal, is_deque_empty = 1 and front_valid = 1. The next cycle front_valid = 0.
- Rst asserted mid-operation: outputs take reset values immediately, without waiting for a clock edge.

## Configuration
- DEQUE_ERR_FLAGS_EN defined: ovf/udf are sticky registers as described, cleared only by Rst or our_reset.
- Not defined: ovf and udf ports remain present but are tied to 0, and their registers are not built. Push-on-full and pop-on-empty are still ignored silently.

## Test plan
- Reset, push 00,01,10,11 on consecutive cycles, then pop_back x4 -> stack_out = 11,10,01,00 on successive cycles; is_deque_empty = 1 after the 4th pop.
- Push 01,01,00, then hold pop_front 3 cycles -> front_out = 01,01,00 with front_valid high 3 cycles; empty after the 3rd; a 4th pop_front keeps front_out = 00, front_valid = 0, udf = 1 (with macro).
- DEPTH = 4: push 5 times -> is_deque_full = 1 after the 4th push; 5th push ignored; ovf = 1 with DEQUE_ERR_FLAGS_EN, ovf = 0 without it.
- Wrap-around, DEPTH = 4: push 3, pop_front 2, push 3 -> count = 4, full; pop_front x4 returns entries in push order across the index 3->0 wrap.
- push and pop_back in the same cycle with count = 2 (back = 10) -> stack_out = 10, count = 1, pushed value discarded.
- Rst pulsed asynchronously between edges with count = 3 -> is_deque_empty = 1 and stack_out = 00 before the next edge; after release, a push of 11 then pop_back returns 11.

Source files
------------

// File: rtl/direction_deque.sv
// Circular-buffer deque of 2-bit maze-solver move directions: push at the back,
// pop from either end. Optional sticky ovf/udf flags are built when DEQUE_ERR_FLAGS_EN is defined.
module direction_deque #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       our_reset,
  input  logic       push,
  input  logic       pop_back,
  input  logic       pop_front,
  input  logic [1:0] dir,
  output logic [1:0] stack_out,
  output logic [1:0] front_out,
  output logic       front_valid,
  output logic       is_deque_empty,
  output logic       is_deque_full,
  output logic       ovf,
  output logic       udf
);

  typedef enum logic [2:0] {
    OP_NONE,
    OP_CLEAR,
    OP_POP_BACK,
    OP_POP_FRONT,
    OP_PUSH
  } op_e;

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] tail_dec;
  logic [AW:0]   count;
  op_e           op;

  assign is_deque_empty = (count == '0);
  assign is_deque_full  = (count == FULL_COUNT);
  assign tail_dec       = tail - AW'(1);

  // One operation per edge; lower-priority requests are dropped without a flag.
  always_comb begin
    op = OP_NONE;
    if (our_reset)      op = OP_CLEAR;
    else if (pop_back)  op = OP_POP_BACK;
    else if (pop_front) op = OP_POP_FRONT;
    else if (push)      op = OP_PUSH;
  end

  // NOTE: the storage array has no reset; entries are only read after being written.
  always_ff @(posedge Clk) begin
    if (op == OP_PUSH && !is_deque_full) mem[tail] <= dir;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      stack_out   <= 2'b00;
      front_out   <= 2'b00;
      front_valid <= 1'b0;
    end else begin
      front_valid <= 1'b0;
      case (op)
        OP_CLEAR: begin
          head      <= '0;
          tail      <= '0;
          count     <= '0;
          stack_out <= 2'b00;
          front_out <= 2'b00;
        end
        OP_POP_BACK: if (!is_deque_empty) begin
          stack_out <= mem[tail_dec];
          tail      <= tail_dec;
          count     <= count - (AW+1)'(1);
        end
        OP_POP_FRONT: if (!is_deque_empty) begin
          front_out   <= mem[head];
          head        <= head + AW'(1);
          count       <= count - (AW+1)'(1);
          front_valid <= 1'b1;
        end
        OP_PUSH: if (!is_deque_full) begin
          tail  <= tail + AW'(1);
          count <= count + (AW+1)'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef DEQUE_ERR_FLAGS_EN
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (op == OP_CLEAR) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (op == OP_PUSH && is_deque_full) ovf <= 1'b1;
      if ((op == OP_POP_BACK || op == OP_POP_FRONT) && is_deque_empty) udf <= 1'b1;
    end
  end
`else
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

endmodule

// File: tb/tb_direction_deque.sv
// Self-checking bench for direction_deque: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic on a DEPTH=4 instance.
module tb_direction_deque;

  localparam int DEPTH = 4;
`ifdef DEQUE_ERR_FLAGS_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       our_reset = 1'b0;
  logic       push = 1'b0;
  logic       pop_back = 1'b0;
  logic       pop_front = 1'b0;
  logic [1:0] dir = 2'b00;
  logic [1:0] stack_out, front_out;
  logic       front_valid, is_deque_empty, is_deque_full, ovf, udf;

  int n_checks = 0;
  int n_fail   = 0;

  direction_deque #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst), .our_reset(our_reset), .push(push), .pop_back(pop_back),
    .pop_front(pop_front), .dir(dir), .stack_out(stack_out), .front_out(front_out),
    .front_valid(front_valid), .is_deque_empty(is_deque_empty),
    .is_deque_full(is_deque_full), .ovf(ovf), .udf(udf)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the deque is a plain SV queue, the rest is remembered values.
  logic [1:0] q[$];
  logic [1:0] m_stack, m_front;
  logic       m_fv, m_ovf, m_udf;

  task automatic model_reset();
    q.delete();
    m_stack = 2'b00; m_front = 2'b00;
    m_fv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  task automatic model_step();
    m_fv = 1'b0;
    if (our_reset) model_reset();
    else if (pop_back) begin
      if (q.size() > 0) m_stack = q.pop_back();
      else m_udf = 1'b1;
    end else if (pop_front) begin
      if (q.size() > 0) begin m_front = q.pop_front(); m_fv = 1'b1; end
      else m_udf = 1'b1;
    end else if (push) begin
      if (q.size() < DEPTH) q.push_back(dir);
      else m_ovf = 1'b1;
    end
  endtask

  initial model_reset();

  always @(posedge Clk or posedge Rst) begin
    if (Rst) model_reset();
    else model_step();
    #1;
    check("mdl_stack_out",   8'(stack_out),      8'(m_stack));
    check("mdl_front_out",   8'(front_out),      8'(m_front));
    check("mdl_front_valid", 8'(front_valid),    8'(m_fv));
    check("mdl_empty",       8'(is_deque_empty), 8'(q.size() == 0));
    check("mdl_full",        8'(is_deque_full),  8'(q.size() == DEPTH));
    check("mdl_ovf",         8'(ovf),            8'(m_ovf & ERR_EN));
    check("mdl_udf",         8'(udf),            8'(m_udf & ERR_EN));
  end

  // Apply one cycle of inputs, then return at the following falling edge.
  task automatic drive(input logic cr, input logic pb, input logic pf, input logic pu,
                       input logic [1:0] d);
    our_reset = cr; pop_back = pb; pop_front = pf; push = pu; dir = d;
    @(negedge Clk);
  endtask

  task automatic do_push(input logic [1:0] d);
    drive(1'b0, 1'b0, 1'b0, 1'b1, d);
  endtask

  initial begin
    logic [1:0] exp_vals[4];

    repeat (2) @(negedge Clk);
    check("rst_stack_out", 8'(stack_out), 8'h0);
    check("rst_front_out", 8'(front_out), 8'h0);
    check("rst_empty",     8'(is_deque_empty), 8'h1);
    check("rst_full",      8'(is_deque_full), 8'h0);
    check("rst_fv",        8'(front_valid), 8'h0);
    Rst = 1'b0;
    @(negedge Clk);

    // LIFO order through pop_back.
    do_push(2'b00);
    check("push1_not_empty", 8'(is_deque_empty), 8'h0);
    do_push(2'b01); do_push(2'b10); do_push(2'b11);
    exp_vals = '{2'b11, 2'b10, 2'b01, 2'b00};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
      check($sformatf("lifo_stack_%0d", i), 8'(stack_out), 8'(exp_vals[i]));
    end
    check("lifo_empty", 8'(is_deque_empty), 8'h1);

    // FIFO replay with pop_front held, then one pop past empty.
    do_push(2'b01); do_push(2'b01); do_push(2'b00);
    exp_vals = '{2'b01, 2'b01, 2'b00, 2'b00};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
      check($sformatf("fifo_front_%0d", i), 8'(front_out), 8'(exp_vals[i]));
      check($sformatf("fifo_fv_%0d", i), 8'(front_valid), 8'h1);
    end
    check("fifo_empty", 8'(is_deque_empty), 8'h1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    check("udf_front_hold", 8'(front_out), 8'h0);
    check("udf_fv_low",     8'(front_valid), 8'h0);
    check("udf_flag",       8'(udf), 8'(ERR_EN));

    // Overflow at DEPTH=4.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    check("clr_udf", 8'(udf), 8'h0);
    do_push(2'b00); do_push(2'b01); do_push(2'b10); do_push(2'b11);
    check("full_after_4", 8'(is_deque_full), 8'h1);
    do_push(2'b01);
    check("full_after_5", 8'(is_deque_full), 8'h1);
    check("ovf_flag",     8'(ovf), 8'(ERR_EN));

    // Wrap-around across index 3 -> 0.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    check("clr_ovf", 8'(ovf), 8'h0);
    do_push(2'b01); do_push(2'b10); do_push(2'b11);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    check("wrap_pre_front", 8'(front_out), 8'h2);
    do_push(2'b00); do_push(2'b01); do_push(2'b10);
    check("wrap_full", 8'(is_deque_full), 8'h1);
    exp_vals = '{2'b11, 2'b00, 2'b01, 2'b10};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
      check($sformatf("wrap_front_%0d", i), 8'(front_out), 8'(exp_vals[i]));
    end

    // push and pop_back together: pop wins, pushed value is discarded.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    do_push(2'b01); do_push(2'b10);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b11);
    check("prio_stack", 8'(stack_out), 8'h2);
    check("prio_not_empty", 8'(is_deque_empty), 8'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    check("prio_stack2", 8'(stack_out), 8'h1);
    check("prio_empty", 8'(is_deque_empty), 8'h1);

    // Asynchronous Rst between edges with three entries held.
    do_push(2'b01); do_push(2'b10); do_push(2'b11); do_push(2'b10);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    check("arst_pre_stack", 8'(stack_out), 8'h2);
    our_reset = 1'b0; pop_back = 1'b0; pop_front = 1'b0; push = 1'b0;
    #2 Rst = 1'b1;
    #1;
    check("arst_empty", 8'(is_deque_empty), 8'h1);
    check("arst_stack", 8'(stack_out), 8'h0);
    #1 Rst = 1'b0;
    @(negedge Clk);
    do_push(2'b11);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    check("arst_after_pop", 8'(stack_out), 8'h3);

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) < 2),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 1) == 1),
            2'($urandom_range(0, 3)));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
